// File: rtl/bit_demux.sv
// Serial 1:2 demultiplexer/deserialiser: MSB-first bits are packed into W-bit words and
// steered to one of two valid/ready holding registers. Define DEMUX_AUTOSEL_EN to alternate channels.
module bit_demux #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_bit,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         in_sel,
    input  logic         in_abort,
    output logic [W-1:0] out0_data,
    output logic         out0_valid,
    input  logic         out0_ready,
    output logic [W-1:0] out1_data,
    output logic         out1_valid,
    input  logic         out1_ready
);

    localparam int unsigned CW = (W > 1) ? $clog2(W) : 1;
    localparam logic [CW-1:0] LAST = CW'(W - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [W-2:0]  sh_q, sh_d;
    logic          lock_ch_q, lock_ch_d;
    logic [W-1:0]  data0_q, data0_d, data1_q, data1_d;
    logic          valid0_q, valid0_d, valid1_q, valid1_d;
    logic          auto_ch_q, auto_ch_d;
    logic          first_ch_c;
    logic          last_c;
    logic          accept_c;

`ifdef DEMUX_AUTOSEL_EN
    logic unused_in_sel;
    assign unused_in_sel = in_sel;
    assign first_ch_c    = auto_ch_q;
`else
    logic unused_auto_ch;
    assign unused_auto_ch = auto_ch_q;
    assign first_ch_c     = in_sel;
`endif

    // Only the last bit can stall, and only on its own channel being full.
    assign last_c   = (cnt_q == LAST);
    assign in_ready = !(last_c && (lock_ch_q ? valid1_q : valid0_q));
    assign accept_c = in_valid && in_ready;

    assign out0_data  = data0_q;
    assign out0_valid = valid0_q;
    assign out1_data  = data1_q;
    assign out1_valid = valid1_q;

    always_comb begin
        cnt_d     = cnt_q;
        sh_d      = sh_q;
        lock_ch_d = lock_ch_q;
        data0_d   = data0_q;
        data1_d   = data1_q;
        valid0_d  = valid0_q;
        valid1_d  = valid1_q;
        auto_ch_d = auto_ch_q;

        if (valid0_q && out0_ready) valid0_d = 1'b0;
        if (valid1_q && out1_ready) valid1_d = 1'b0;

        if (in_abort) begin
            cnt_d = '0;
            sh_d  = '0;
        end else if (accept_c) begin
            if (cnt_q == '0) begin
                lock_ch_d = first_ch_c;
                sh_d      = (W-1)'(in_bit);
                cnt_d     = CW'(1);
            end else if (!last_c) begin
                sh_d  = (W-1)'({sh_q, in_bit});
                cnt_d = cnt_q + CW'(1);
            end else begin
                // in_ready guarantees the target holding register is empty here.
                if (lock_ch_q) begin
                    data1_d  = {sh_q, in_bit};
                    valid1_d = 1'b1;
                end else begin
                    data0_d  = {sh_q, in_bit};
                    valid0_d = 1'b1;
                end
                cnt_d     = '0;
                auto_ch_d = !auto_ch_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            sh_q      <= '0;
            lock_ch_q <= 1'b0;
            data0_q   <= '0;
            data1_q   <= '0;
            valid0_q  <= 1'b0;
            valid1_q  <= 1'b0;
            auto_ch_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            sh_q      <= sh_d;
            lock_ch_q <= lock_ch_d;
            data0_q   <= data0_d;
            data1_q   <= data1_d;
            valid0_q  <= valid0_d;
            valid1_q  <= valid1_d;
            auto_ch_q <= auto_ch_d;
        end
    end

endmodule

// File: tb/tb_bit_demux.sv
// Self-checking bench for bit_demux (W=8): table-driven routing plus hand-written
// backpressure, independence, reset and abort sequences; delivered words checked by a scoreboard.
module tb_bit_demux;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_bit, in_valid, in_ready, in_sel, in_abort;
    logic [7:0] out0_data, out1_data;
    logic       out0_valid, out0_ready, out1_valid, out1_ready;

    int n_cmp = 0;
    int n_err = 0;
    int n_stall = 0;
    logic auto_n = 1'b0;
    logic [7:0] q0[$];
    logic [7:0] q1[$];

    typedef struct {
        logic [7:0] word;
        logic       sel;
        logic       mid_toggle;
        int         gap;
        logic       exp_ch;
        logic [7:0] exp_data;
    } vec_t;

    bit_demux #(.W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_bit(in_bit), .in_valid(in_valid), .in_ready(in_ready),
        .in_sel(in_sel), .in_abort(in_abort),
        .out0_data(out0_data), .out0_valid(out0_valid), .out0_ready(out0_ready),
        .out1_data(out1_data), .out1_valid(out1_valid), .out1_ready(out1_ready)
    );

    always #5 clk = ~clk;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    function automatic logic dest(input logic s);
`ifdef DEMUX_AUTOSEL_EN
        dest   = auto_n;
        auto_n = ~auto_n;
`else
        dest = s;
`endif
    endfunction

    // Scoreboard: a word is delivered on any edge where valid && ready.
    always @(negedge clk) begin
        if (rst_n) begin
            if (out0_valid && out0_ready) begin
                if (q0.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL sb_ch0_unexpected: got %0h expected none", out0_data);
                end else check("sb_ch0", 32'(out0_data), 32'(q0.pop_front()));
            end
            if (out1_valid && out1_ready) begin
                if (q1.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL sb_ch1_unexpected: got %0h expected none", out1_data);
                end else check("sb_ch1", 32'(out1_data), 32'(q1.pop_front()));
            end
        end
    end

    task automatic send_bit(input logic b, input logic s);
        int guard = 0;
        in_bit = b; in_sel = s; in_valid = 1'b1;
        if (!in_ready) n_stall++;
        while (!in_ready && guard < 200) begin
            @(posedge clk); #1;
            guard++;
        end
        if (guard >= 200) begin
            n_cmp++; n_err++;
            $display("FAIL stall_timeout: got in_ready=0 expected 1 within 200 cycles");
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic send_word(input logic [7:0] w, input logic s, input logic tog, input int gap);
        for (int i = 7; i >= 0; i--) begin
            send_bit(w[i], (tog && i >= 2 && i <= 4) ? ~s : s);
            if (i > 0) repeat (gap) begin @(posedge clk); #1; end
        end
    endtask

    task automatic push(input logic ch, input logic [7:0] w);
        if (ch) q1.push_back(w); else q0.push_back(w);
    endtask

    initial begin
        vec_t tbl[5];
        logic ch;
        tbl[0] = '{8'hB2, 1'b0, 1'b0, 0, 1'b0, 8'hB2};
        tbl[1] = '{8'h5A, 1'b1, 1'b1, 0, 1'b1, 8'h5A};
        tbl[2] = '{8'hC3, 1'b0, 1'b0, 2, 1'b0, 8'hC3};
        tbl[3] = '{8'h00, 1'b1, 1'b0, 0, 1'b1, 8'h00};
        tbl[4] = '{8'hFF, 1'b0, 1'b1, 1, 1'b0, 8'hFF};

        rst_n = 1'b0; in_bit = 0; in_valid = 0; in_sel = 0; in_abort = 0;
        out0_ready = 1'b1; out1_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(in_ready), 1);
        check("rst_out0_valid", 32'(out0_valid), 0);
        check("rst_out1_valid", 32'(out1_valid), 0);
        check("rst_out0_data", 32'(out0_data), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

`ifdef DEMUX_AUTOSEL_EN
        for (int i = 1; i <= 4; i++) begin
            ch = dest(1'b1);
            check("auto_dest", 32'(ch), 32'((i - 1) % 2));
            push(ch, 8'(i));
            send_word(8'(i), 1'b1, 1'b0, 0);
            check("auto_valid", 32'(ch ? out1_valid : out0_valid), 1);
            check("auto_data", 32'(ch ? out1_data : out0_data), 32'(i));
        end
`endif

        // Routing table, consumers always ready.
        for (int i = 0; i < 5; i++) begin
`ifdef DEMUX_AUTOSEL_EN
            ch = dest(tbl[i].sel);
`else
            ch = tbl[i].exp_ch;
`endif
            push(ch, tbl[i].exp_data);
            send_word(tbl[i].word, tbl[i].sel, tbl[i].mid_toggle, tbl[i].gap);
            check($sformatf("tbl%0d_valid", i), 32'(ch ? out1_valid : out0_valid), 1);
            check($sformatf("tbl%0d_data", i), 32'(ch ? out1_data : out0_data), 32'(tbl[i].exp_data));
            check($sformatf("tbl%0d_other_valid", i), 32'(ch ? out0_valid : out1_valid), 0);
        end
        repeat (2) begin @(posedge clk); #1; end

`ifndef DEMUX_AUTOSEL_EN
        // Backpressure on channel 0: last bit stalls until the drain.
        out0_ready = 1'b0;
        push(1'b0, 8'hB2);
        send_word(8'hB2, 1'b0, 1'b0, 0);
        check("bp_first_valid", 32'(out0_valid), 1);
        push(1'b0, 8'h3C);
        for (int i = 7; i >= 1; i--) send_bit(1'(8'h3C >> i), 1'b0);
        in_bit = 1'b0; in_sel = 1'b0; in_valid = 1'b1;
        check("bp_ready_low_cnt7", 32'(in_ready), 0);
        @(posedge clk); #1;
        check("bp_ready_still_low", 32'(in_ready), 0);
        check("bp_data_held", 32'(out0_data), 32'h B2);
        out0_ready = 1'b1;
        @(posedge clk); #1;
        out0_ready = 1'b0;
        check("bp_ready_after_drain", 32'(in_ready), 1);
        check("bp_valid_drained", 32'(out0_valid), 0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("bp_second_valid", 32'(out0_valid), 1);
        check("bp_second_data", 32'(out0_data), 32'h3C);

        // Channel 1 proceeds while channel 0 stays full.
        out1_ready = 1'b0;
        n_stall = 0;
        push(1'b1, 8'hFF);
        send_word(8'hFF, 1'b1, 1'b0, 0);
        check("ind_no_stall", 32'(n_stall), 0);
        check("ind_out1_valid", 32'(out1_valid), 1);
        check("ind_out1_data", 32'(out1_data), 32'hFF);
        check("ind_out0_still_full", 32'(out0_valid), 1);
        out0_ready = 1'b1; out1_ready = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
`endif

        // Reset mid-word.
        send_bit(1'b1, 1'b1); send_bit(1'b0, 1'b1); send_bit(1'b1, 1'b1);
        rst_n = 1'b0;
        auto_n = 1'b0;
        #1;
        check("mid_rst_in_ready", 32'(in_ready), 1);
        check("mid_rst_out0_valid", 32'(out0_valid), 0);
        check("mid_rst_out1_valid", 32'(out1_valid), 0);
        check("mid_rst_out0_data", 32'(out0_data), 0);
        check("mid_rst_out1_data", 32'(out1_data), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        ch = dest(1'b0);
        push(ch, 8'hA5);
        send_word(8'hA5, 1'b0, 1'b0, 0);
        check("post_rst_valid", 32'(ch ? out1_valid : out0_valid), 1);
        check("post_rst_data", 32'(ch ? out1_data : out0_data), 32'hA5);
        repeat (2) begin @(posedge clk); #1; end

        // Abort after four bits; the presented bit is dropped too.
        for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b1);
        in_abort = 1'b1; in_valid = 1'b1; in_bit = 1'b1;
        @(posedge clk); #1;
        in_abort = 1'b0; in_valid = 1'b0;
        ch = dest(1'b0);
        push(ch, 8'h69);
        send_word(8'h69, 1'b0, 1'b0, 0);
        check("post_abort_valid", 32'(ch ? out1_valid : out0_valid), 1);
        check("post_abort_data", 32'(ch ? out1_data : out0_data), 32'h69);
        check("post_abort_other", 32'(ch ? out0_valid : out1_valid), 0);

        repeat (5) begin @(posedge clk); #1; end
        check("sb_ch0_drained", 32'(q0.size()), 0);
        check("sb_ch1_drained", 32'(q1.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
